// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - MEM-stage store buffer bus: store/load requests and data-memory port
interface store_buffer_if #(parameter int AW = 2);
  logic          st_valid;
  logic [1:0]    st_type;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          stall;
  logic          misalign;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [3:0]    dm_bsel;
  logic [31:0]   dm_wdata;
  logic          empty;
  logic [AW:0]   count;

  modport master (
    output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr,
    input  stall, misalign, dm_we, dm_addr, dm_bsel, dm_wdata, empty, count
  );
  modport slave (
    input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr,
    output stall, misalign, dm_we, dm_addr, dm_bsel, dm_wdata, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO in front of the single data-memory port
// Loads take the port when safe; otherwise the oldest store drains.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    bsel_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;

  logic [3:0]    st_bsel;
  logic [31:0]   st_wdata;
  logic          misalign_c, enq, ld_eff, hazard, full, grant, drain, empty_c;
  logic [AW-1:0] offs;

  always_comb begin
    st_bsel  = 4'b1111;
    st_wdata = bus.st_data;
    case (bus.st_type)
      2'b01: begin
        st_bsel  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.st_data[15:0]}};
      end
      2'b10: begin
        st_bsel  = 4'b0001 << bus.st_addr[1:0];
        st_wdata = {4{bus.st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign misalign_c = bus.st_valid & ((bus.st_type == 2'b11) |
                      ((bus.st_type == 2'b00) & (bus.st_addr[1:0] != 2'b00)) |
                      ((bus.st_type == 2'b01) & bus.st_addr[0]));
  assign enq     = bus.st_valid & ~misalign_c;
  // A store in the same cycle wins; the load request is ignored.
  assign ld_eff  = bus.ld_valid & ~bus.st_valid;
  assign empty_c = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr;
      if (({1'b0, offs} < count_q) && (addr_q[i] == bus.ld_addr[31:2]))
        hazard = ld_eff;
    end
  end

  assign grant = ld_eff & ~hazard & ~full;
  assign drain = ~empty_c & ~grant;

  always_comb begin
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_bsel  = 4'h0;
    bus.dm_wdata = 32'h0;
    if (reset) begin
      if (grant) begin
        bus.dm_addr = {bus.ld_addr[31:2], 2'b00};
      end else if (drain) begin
        bus.dm_we    = 1'b1;
        bus.dm_addr  = {addr_q[rd_ptr], 2'b00};
        bus.dm_bsel  = bsel_q[rd_ptr];
        bus.dm_wdata = data_q[rd_ptr];
      end
    end
  end

  assign bus.stall    = reset & ld_eff & (hazard | full);
  assign bus.misalign = reset & misalign_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + AW'(1);
      if (drain) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, drain};
    end
  end

  // When full, the write lands on the head slot that is draining this same edge.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= bus.st_addr[31:2];
      bsel_q[wr_ptr] <= st_bsel;
      data_q[wr_ptr] <= st_wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed checks of store_buffer against a queue model
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(AW)) bus ();
  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [29:0] wa;
    logic [3:0]  bs;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [1:0] t);
    return (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
  endfunction

  function automatic bit is_misal(input logic v, input logic [1:0] t, input logic [31:0] a);
    return v && ((t == 2'b11) || ((int'(a[1:0]) % acc_size(t)) != 0));
  endfunction

  // Each lane is enabled if it falls inside the accessed bytes; lane k carries source byte k mod size.
  function automatic ent_t fmt(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int sz, base;
    sz   = acc_size(t);
    base = (int'(a[1:0]) / sz) * sz;
    e.wa = a[31:2];
    e.bs = 4'h0;
    e.wd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k >= base && k < base + sz) e.bs[k] = 1'b1;
      e.wd[8*k +: 8] = d[8*(k % sz) +: 8];
    end
    return e;
  endfunction

  function automatic bit in_queue(input logic [31:0] la);
    foreach (q[i]) if (q[i].wa == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit load_granted();
    bit ldv;
    ldv = bus.ld_valid && !bus.st_valid;
    return ldv && !in_queue(bus.ld_addr) && (q.size() != DEPTH);
  endfunction

  always @(posedge clk) begin
    if (!reset) q.delete();
    else begin
      if (q.size() > 0 && !load_granted()) void'(q.pop_front());
      if (bus.st_valid && !is_misal(1'b1, bus.st_type, bus.st_addr))
        q.push_back(fmt(bus.st_type, bus.st_addr, bus.st_data));
    end
  end

  always @(negedge clk) begin
    bit ldv, haz, full_m;
    if (!reset) begin
      check("rst_we", bus.dm_we, 0);
      check("rst_addr", bus.dm_addr, 0);
      check("rst_bsel", bus.dm_bsel, 0);
      check("rst_wdata", bus.dm_wdata, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_misalign", bus.misalign, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_count", bus.count, 0);
    end else begin
      ldv    = bus.ld_valid && !bus.st_valid;
      haz    = ldv && in_queue(bus.ld_addr);
      full_m = (q.size() == DEPTH);
      if (load_granted()) begin
        check("grant_we", bus.dm_we, 0);
        check("grant_addr", bus.dm_addr, {bus.ld_addr[31:2], 2'b00});
        check("grant_bsel", bus.dm_bsel, 0);
      end else if (q.size() > 0) begin
        check("drain_we", bus.dm_we, 1);
        check("drain_addr", bus.dm_addr, {q[0].wa, 2'b00});
        check("drain_bsel", bus.dm_bsel, q[0].bs);
        check("drain_wdata", bus.dm_wdata, q[0].wd);
      end else begin
        check("idle_we", bus.dm_we, 0);
        check("idle_addr", bus.dm_addr, 0);
        check("idle_bsel", bus.dm_bsel, 0);
      end
      check("stall", bus.stall, ldv && (haz || full_m));
      check("misalign", bus.misalign, is_misal(bus.st_valid, bus.st_type, bus.st_addr));
      check("empty", bus.empty, q.size() == 0);
      check("count", bus.count, q.size());
    end
  end

  task automatic drive(input bit sv, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input bit lv, input logic [31:0] la);
    bus.st_valid = sv;
    bus.st_type  = t;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
  endtask

  task automatic idle();
    drive(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    logic [31:0] a, la;
    idle();
    @(negedge clk);
    check("t_rst_empty", bus.empty, 1);
    check("t_rst_we", bus.dm_we, 0);
    tick();
    tick();
    reset = 1'b1;

    drive(1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 0);
    @(negedge clk); check("t_sw_count0", bus.count, 0);
    tick(); idle();
    @(negedge clk);
    check("t_sw_we", bus.dm_we, 1);
    check("t_sw_addr", bus.dm_addr, 32'h10);
    check("t_sw_bsel", bus.dm_bsel, 4'b1111);
    check("t_sw_wdata", bus.dm_wdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("t_sw_empty", bus.empty, 1);
    check("t_sw_count", bus.count, 0);

    drive(1, 2'b10, 32'h23, 32'h000000A5, 0, 0);
    tick(); idle();
    @(negedge clk);
    check("t_sb_bsel", bus.dm_bsel, 4'b1000);
    check("t_sb_wdata", bus.dm_wdata, 32'hA5A5A5A5);
    check("t_sb_addr", bus.dm_addr, 32'h20);
    tick();
    drive(1, 2'b01, 32'h22, 32'h00001234, 0, 0);
    tick(); idle();
    @(negedge clk);
    check("t_sh_bsel", bus.dm_bsel, 4'b1100);
    check("t_sh_wdata", bus.dm_wdata, 32'h12341234);
    tick();

    drive(1, 2'b00, 32'h40, 32'h11112222, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 1, 32'h42);
    @(negedge clk);
    check("t_hz_stall", bus.stall, 1);
    check("t_hz_drain", bus.dm_we, 1);
    tick();
    @(negedge clk);
    check("t_hz_release", bus.stall, 0);
    check("t_hz_ld_we", bus.dm_we, 0);
    check("t_hz_ld_addr", bus.dm_addr, 32'h40);
    tick();

    drive(1, 2'b00, 32'h100, 32'h1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b00, 0, 0, 1, 32'h200 + 32'(4 * i));
      @(negedge clk);
      check("t_ls_we", bus.dm_we, 0);
      check("t_ls_count", bus.count, 1);
      tick();
    end
    idle();
    @(negedge clk);
    check("t_ls_drain_addr", bus.dm_addr, 32'h100);
    tick();

    drive(1, 2'b00, 32'h13, 32'h5, 0, 0);
    @(negedge clk); check("t_mis_sw", bus.misalign, 1); check("t_mis_stall", bus.stall, 0);
    tick();
    drive(1, 2'b01, 32'h11, 32'h5, 0, 0);
    @(negedge clk); check("t_mis_sh", bus.misalign, 1);
    tick();
    drive(1, 2'b11, 32'h20, 32'h5, 0, 0);
    @(negedge clk); check("t_mis_ill", bus.misalign, 1);
    tick(); idle();
    @(negedge clk); check("t_mis_count", bus.count, 0);
    tick();

    drive(1, 2'b00, 32'h80, 32'h7, 1, 32'h80);
    @(negedge clk); check("t_both_stall", bus.stall, 0);
    tick();

    drive(1, 2'b00, 32'h300, 32'h9, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 1, 32'h400);
    #2 reset = 1'b0;
    #1;
    check("t_ar_count", bus.count, 0);
    check("t_ar_we", bus.dm_we, 0);
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("t_ar_post_we", bus.dm_we, 0);
    tick();

    for (int c = 0; c < 600; c++) begin
      r  = $urandom_range(0, 9);
      a  = {26'h0, 6'($urandom)};
      la = {26'h0, 6'($urandom)};
      if (r < 4)
        drive(1, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), a, $urandom, 0, 0);
      else if (r < 8)
        drive(0, 2'b00, 0, 0, 1, la);
      else if (r == 8)
        drive(1, 2'($urandom_range(0, 2)), a, $urandom, 1, la);
      else
        idle();
      tick();
    end
    idle();
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
